// File: rtl/seq_det_sched_if.sv
// Signal bundle between seq_det_sched, its byte requesters and the shared serial detector.
// The slave modport is the scheduler's view; the master modport is the environment's view.
interface seq_det_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       req;
  logic [8*NUM_CH-1:0]     data;
  logic [NUM_CH-1:0]       ack;
  logic [NUM_CH-1:0]       grant;
  logic                    busy;
  logic                    det_din;
  logic                    det_valid;
  logic                    det_clr;
  logic                    det_hit;
  logic [NUM_CH-1:0]       cnt_clr;
  logic [CNT_W*NUM_CH-1:0] hit_cnt;
  logic                    hit_irq;
  logic [2:0]              hit_ch;

  modport slave (
    input  req, data, det_hit, cnt_clr,
    output ack, grant, busy, det_din, det_valid, det_clr, hit_cnt, hit_irq, hit_ch
  );

  modport master (
    output req, data, det_hit, cnt_clr,
    input  ack, grant, busy, det_din, det_valid, det_clr, hit_cnt, hit_irq, hit_ch
  );
endinterface

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial sequence detector among NUM_CH byte requesters.
// Define SEQ_SCHED_LSB_FIRST_EN to serialize bytes LSB first instead of MSB first.
module seq_det_sched #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int DRAIN  = 2
) (
  input  logic           clk,
  input  logic           rst,
  seq_det_sched_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_CLEAR} state_t;

  state_t            state_q, state_d;
  logic [7:0]        shReg_q, shReg_d;
  logic [2:0]        bitCnt_q, bitCnt_d;
  logic [2:0]        drainCnt_q, drainCnt_d;
  logic [2:0]        last_q, last_d;
  logic [2:0]        hitCh_q, hitCh_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic              hitPrev_q, hitPrev_d;
  logic              hitIrq_q, hitIrq_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];

  logic              found;
  logic [2:0]        winIdx;
  logic [7:0]        winByte;
  logic [7:0]        shifted;
  logic              serialBit;
  logic              credit;

`ifdef SEQ_SCHED_LSB_FIRST_EN
  assign serialBit = shReg_q[0];
  assign shifted   = {1'b0, shReg_q[7:1]};
`else
  assign serialBit = shReg_q[7];
  assign shifted   = {shReg_q[6:0], 1'b0};
`endif

  // Search starts one past the last owner so a re-requesting channel goes to the back of the line.
  always_comb begin
    found   = 1'b0;
    winIdx  = last_q;
    winByte = 8'h00;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && bus.req[i] && (i == ((int'(last_q) + k) % NUM_CH))) begin
          found  = 1'b1;
          winIdx = 3'(i);
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(winIdx) == i) winByte = bus.data[8*i +: 8];
    end
  end

  assign credit = ((state_q == S_SHIFT) || (state_q == S_DRAIN)) && bus.det_hit && !hitPrev_q;

  always_comb begin
    state_d    = state_q;
    shReg_d    = shReg_q;
    bitCnt_d   = bitCnt_q;
    drainCnt_d = drainCnt_q;
    last_d     = last_q;
    grant_d    = grant_q;
    ack_d      = '0;
    hitPrev_d  = hitPrev_q;
    hitIrq_d   = 1'b0;
    hitCh_d    = hitCh_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          shReg_d  = winByte;
          last_d   = winIdx;
          bitCnt_d = 3'd0;
          for (int i = 0; i < NUM_CH; i++) begin
            grant_d[i] = (int'(winIdx) == i);
            ack_d[i]   = (int'(winIdx) == i);
          end
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shReg_d   = shifted;
        bitCnt_d  = bitCnt_q + 3'd1;
        hitPrev_d = bus.det_hit;
        if (bitCnt_q == 3'd7) begin
          drainCnt_d = 3'd0;
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drainCnt_d = drainCnt_q + 3'd1;
        hitPrev_d  = bus.det_hit;
        if (drainCnt_q == 3'(DRAIN - 1)) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        grant_d   = '0;
        hitPrev_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (credit) begin
      hitIrq_d = 1'b1;
      hitCh_d  = last_q;
    end
  end

  // A clear on the same cycle as a credit wins; the interrupt still fires.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (credit && (int'(last_q) == i) && (cnt_q[i] != {CNT_W{1'b1}})) cnt_d[i] = cnt_q[i] + 1'b1;
      if (bus.cnt_clr[i]) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shReg_q    <= 8'h00;
      bitCnt_q   <= 3'd0;
      drainCnt_q <= 3'd0;
      last_q     <= 3'(NUM_CH - 1);
      grant_q    <= '0;
      ack_q      <= '0;
      hitPrev_q  <= 1'b0;
      hitIrq_q   <= 1'b0;
      hitCh_q    <= 3'd0;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      shReg_q    <= shReg_d;
      bitCnt_q   <= bitCnt_d;
      drainCnt_q <= drainCnt_d;
      last_q     <= last_d;
      grant_q    <= grant_d;
      ack_q      <= ack_d;
      hitPrev_q  <= hitPrev_d;
      hitIrq_q   <= hitIrq_d;
      hitCh_q    <= hitCh_d;
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.ack       = ack_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.det_valid = (state_q == S_SHIFT);
  assign bus.det_din   = (state_q == S_SHIFT) ? serialBit : 1'b0;
  assign bus.det_clr   = (state_q == S_CLEAR);
  assign bus.hit_irq   = hitIrq_q;
  assign bus.hit_ch    = hitCh_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign bus.hit_cnt[CNT_W*g +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched with CNT_W=2, driving an overlapping 01101 Moore detector model.
module tb_seq_det_sched;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int DR  = 2;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  seq_det_sched_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  seq_det_sched #(.NUM_CH(NCH), .CNT_W(CW), .DRAIN(DR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Overlapping Moore detector for 01101; state 5 means the full pattern was just seen.
  logic [2:0] detSt;

  function automatic logic [2:0] detNext(input logic [2:0] s, input logic b);
    case (s)
      3'd0:    return b ? 3'd0 : 3'd1;
      3'd1:    return b ? 3'd2 : 3'd1;
      3'd2:    return b ? 3'd3 : 3'd1;
      3'd3:    return b ? 3'd0 : 3'd4;
      3'd4:    return b ? 3'd5 : 3'd1;
      3'd5:    return b ? 3'd3 : 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)                detSt <= 3'd0;
    else if (bus.det_clr)   detSt <= 3'd0;
    else if (bus.det_valid) detSt <= detNext(detSt, bus.det_din);
  end

  assign bus.det_hit = (detSt == 3'd5);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.data = '0;
    bus.cnt_clr = '0;
    #12;
    total++;
    if ({bus.ack, bus.grant, bus.busy, bus.det_din, bus.det_valid, bus.det_clr,
         bus.hit_irq, bus.hit_ch, bus.hit_cnt} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got ack=%b grant=%b busy=%b cnt=%h want all zero",
               bus.ack, bus.grant, bus.busy, bus.hit_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    total++;
    if ({bus.busy, bus.grant} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_idle: got busy=%b grant=%b want 0 0", bus.busy, bus.grant);
    end
  endtask

  task automatic test_round_robin();
    int         expCyc[5] = '{2, 14, 26, 38, 50};
    logic [3:0] expAck[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         gotCyc[5] = '{default: 0};
    logic [3:0] gotAck[5] = '{default: 4'b0000};
    logic [3:0] gotGnt[5] = '{default: 4'b0000};
    int n = 0;
    int nIrq = 0;
    int w = 0;
    bus.data = 32'h0000_0000;
    bus.req  = 4'b1111;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (bus.ack != 4'b0000 && n < 5) begin
        gotCyc[n] = cyc;
        gotAck[n] = bus.ack;
        gotGnt[n] = bus.grant;
        n++;
      end
      if (bus.hit_irq) nIrq++;
      if (cyc < 50) tick();
    end
    bus.req = 4'b0000;
    while (bus.busy && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (n !== 5) begin
      bad++;
      $display("[TB] FAIL rr_count: got %0d grants want 5", n);
    end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (gotCyc[k] !== expCyc[k] || gotAck[k] !== expAck[k] || gotGnt[k] !== expAck[k]) begin
        bad++;
        $display("[TB] FAIL rr_grant%0d: got cyc=%0d ack=%b grant=%b want cyc=%0d ack=grant=%b",
                 k, gotCyc[k], gotAck[k], gotGnt[k], expCyc[k], expAck[k]);
      end
    end
    total++;
    if (nIrq !== 0) begin
      bad++;
      $display("[TB] FAIL rr_irq: got %0d irqs want 0", nIrq);
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rr_drain_timeout: got busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_single();
    int ackCyc = 0;
    int clrCyc = 0;
    int idleCyc = 0;
    int nValid = 0;
    int nIrq = 0;
    int irqA = 0;
    int irqB = 0;
    int badCh = 0;
    logic [7:0] stream = 8'h00;
    bus.data = 32'h0000_006D;
    bus.req  = 4'b0001;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      if (bus.ack[0] && ackCyc == 0) ackCyc = cyc;
      if (bus.det_valid) begin
        stream = {stream[6:0], bus.det_din};
        nValid++;
      end
      if (bus.hit_irq) begin
        nIrq++;
        if (nIrq == 1) irqA = cyc;
        else if (nIrq == 2) irqB = cyc;
        if (bus.hit_ch !== 3'd0) badCh++;
      end
      if (bus.det_clr && clrCyc == 0) clrCyc = cyc;
      if (!bus.busy && cyc > 1 && idleCyc == 0) idleCyc = cyc;
      if (cyc == 2) bus.req = 4'b0000;
      tick();
    end
    total++;
    if (ackCyc !== 2) begin bad++; $display("[TB] FAIL single_ack: got cycle %0d want 2", ackCyc); end
    total++;
    if (stream !== 8'h6D || nValid !== 8) begin
      bad++;
      $display("[TB] FAIL single_stream: got %h (%0d bits) want 6d (8 bits)", stream, nValid);
    end
    total++;
    if (nIrq !== 2 || irqA !== 8 || irqB !== 11) begin
      bad++;
      $display("[TB] FAIL single_irq: got n=%0d at %0d,%0d want n=2 at 8,11", nIrq, irqA, irqB);
    end
    total++;
    if (badCh !== 0) begin bad++; $display("[TB] FAIL single_hit_ch: got %0d wrong want 0", badCh); end
    total++;
    if (clrCyc !== 12) begin bad++; $display("[TB] FAIL single_clr: got cycle %0d want 12", clrCyc); end
    total++;
    if (idleCyc !== 13) begin bad++; $display("[TB] FAIL single_idle: got cycle %0d want 13", idleCyc); end
    total++;
    if (bus.hit_cnt[1:0] !== 2'd2) begin
      bad++;
      $display("[TB] FAIL single_cnt: got %0d want 2", bus.hit_cnt[1:0]);
    end
  endtask

  task automatic test_all_ones();
    int ackCyc = 0;
    int clrCyc = 0;
    int nIrq = 0;
    logic [3:0] gnt = 4'b0000;
    logic [7:0] stream = 8'h00;
    bus.data = 32'h00FF_0000;
    bus.req  = 4'b0100;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      if (bus.ack[2] && ackCyc == 0) begin
        ackCyc = cyc;
        gnt = bus.grant;
      end
      if (bus.det_valid) stream = {stream[6:0], bus.det_din};
      if (bus.hit_irq) nIrq++;
      if (bus.det_clr && clrCyc == 0) clrCyc = cyc;
      if (cyc == 2) bus.req = 4'b0000;
      tick();
    end
    total++;
    if (ackCyc !== 2 || gnt !== 4'b0100) begin
      bad++;
      $display("[TB] FAIL ones_grant: got cycle %0d grant %b want 2 0100", ackCyc, gnt);
    end
    total++;
    if (stream !== 8'hFF) begin bad++; $display("[TB] FAIL ones_stream: got %h want ff", stream); end
    total++;
    if (nIrq !== 0 || bus.hit_cnt[5:4] !== 2'd0) begin
      bad++;
      $display("[TB] FAIL ones_nohit: got irq=%0d cnt=%0d want 0 0", nIrq, bus.hit_cnt[5:4]);
    end
    total++;
    if (clrCyc !== 12) begin bad++; $display("[TB] FAIL ones_clr: got cycle %0d want 12", clrCyc); end
  endtask

  task automatic test_saturate();
    int nAck = 0;
    int nIrq = 0;
    int badCh = 0;
    bus.data = 32'h0000_6D00;
    bus.req  = 4'b0010;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.ack[1]) begin
        nAck++;
        if (nAck == 3) bus.req = 4'b0000;
      end
      if (bus.hit_irq) begin
        nIrq++;
        if (bus.hit_ch !== 3'd1) badCh++;
      end
      tick();
    end
    total++;
    if (nAck !== 3) begin bad++; $display("[TB] FAIL sat_acks: got %0d want 3", nAck); end
    total++;
    if (nIrq !== 6 || badCh !== 0) begin
      bad++;
      $display("[TB] FAIL sat_irq: got %0d irqs (%0d wrong ch) want 6 (0)", nIrq, badCh);
    end
    total++;
    if (bus.hit_cnt[3:2] !== 2'd3) begin
      bad++;
      $display("[TB] FAIL sat_cnt: got %0d want 3", bus.hit_cnt[3:2]);
    end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL sat_idle: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_clr_collision();
    bus.data = 32'h0000_006D;
    bus.req  = 4'b0001;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      if (cyc == 2) bus.req = 4'b0000;
      if (cyc == 7) bus.cnt_clr = 4'b0001;
      if (cyc == 8) begin
        bus.cnt_clr = 4'b0000;
        total++;
        if (bus.hit_irq !== 1'b1 || bus.hit_ch !== 3'd0 || bus.hit_cnt[1:0] !== 2'd0) begin
          bad++;
          $display("[TB] FAIL clr_collide: got irq=%b ch=%0d cnt=%0d want 1 0 0",
                   bus.hit_irq, bus.hit_ch, bus.hit_cnt[1:0]);
        end
      end
      tick();
    end
    total++;
    if (bus.hit_cnt[1:0] !== 2'd1) begin
      bad++;
      $display("[TB] FAIL clr_after: got %0d want 1", bus.hit_cnt[1:0]);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL clr_idle: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_shift();
    bus.data = 32'h0000_FF00;
    bus.req  = 4'b0010;
    for (int cyc = 1; cyc < 5; cyc++) tick();
    total++;
    if (bus.det_valid !== 1'b1 || bus.det_din !== 1'b1 || bus.grant !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL rst_pre: got valid=%b din=%b grant=%b want 1 1 0010",
               bus.det_valid, bus.det_din, bus.grant);
    end
    rst = 1'b1;
    #1;
    total++;
    if ({bus.ack, bus.grant, bus.busy, bus.det_din, bus.det_valid, bus.det_clr,
         bus.hit_irq, bus.hit_ch, bus.hit_cnt} !== '0) begin
      bad++;
      $display("[TB] FAIL rst_async: got grant=%b busy=%b din=%b valid=%b cnt=%h want all zero",
               bus.grant, bus.busy, bus.det_din, bus.det_valid, bus.hit_cnt);
    end
    #2;
    rst = 1'b0;
    tick();
    total++;
    if (bus.grant !== 4'b0010 || bus.ack !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL rst_regrant: got grant=%b ack=%b want 0010 0010", bus.grant, bus.ack);
    end
    bus.req = 4'b0000;
    for (int cyc = 0; cyc < 12; cyc++) tick();
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_idle: got busy=%b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_all_ones();
    test_saturate();
    test_clr_collision();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion want completion before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
